// File: rtl/imm_pkg.sv
// Shared decode constants, immediate format codes and skid-buffer state encoding
// for the registered immediate generator.
package imm_pkg;

  localparam logic [6:0] itype_l = 7'b0000011;  // LOAD
  localparam logic [6:0] itype_a = 7'b0010011;  // OP-IMM
  localparam logic [6:0] itype_j = 7'b1100111;  // JALR
  localparam logic [6:0] itype_w = 7'b0011011;  // OP-IMM-32
  localparam logic [6:0] stype   = 7'b0100011;
  localparam logic [6:0] btype   = 7'b1100011;
  localparam logic [6:0] utype_l = 7'b0110111;  // LUI
  localparam logic [6:0] utype_u = 7'b0010111;  // AUIPC
  localparam logic [6:0] jtype   = 7'b1101111;
  localparam logic [6:0] sys     = 7'b1110011;
  localparam logic [6:0] fence   = 7'b0001111;

  typedef enum logic [2:0] {
    fmt_none  = 3'd0,
    fmt_i     = 3'd1,
    fmt_s     = 3'd2,
    fmt_b     = 3'd3,
    fmt_u     = 3'd4,
    fmt_j     = 3'd5,
    fmt_shamt = 3'd6,
    fmt_zimm  = 3'd7
  } fmt_e;

  typedef enum logic [1:0] {
    st_empty = 2'd0,
    st_busy  = 2'd1,
    st_full  = 2'd2
  } state_e;

endpackage

// File: rtl/imm_gen_pipe_extract.sv
// Combinational immediate extraction: instruction word to extended immediate,
// format code and illegal flag for the configured XLEN.
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt,
  output logic            illegal
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_shift;
  logic [31:0] imm_i;
  logic [31:0] imm32;

  assign opcode   = inst[6:0];
  assign funct3   = inst[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
  assign imm_i    = {{20{inst[31]}}, inst[31:20]};

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    imm32   = '0;
    fmt     = fmt_none;
    illegal = 1'b0;
    case (opcode)
      itype_l, itype_j: begin
        fmt   = fmt_i;
        imm32 = imm_i;
      end
      itype_a: begin
        if (is_shift) begin
          fmt = fmt_shamt;
          if (XLEN == 64) begin
            imm32 = {26'b0, inst[25:20]};
          end else begin
            imm32   = {27'b0, inst[24:20]};
            illegal = inst[25];
          end
        end else begin
          fmt   = fmt_i;
          imm32 = imm_i;
        end
      end
      itype_w: begin
        if (XLEN == 32) begin
          illegal = 1'b1;
        end else if (is_shift) begin
          fmt   = fmt_shamt;
          imm32 = {27'b0, inst[24:20]};
        end else begin
          fmt   = fmt_i;
          imm32 = imm_i;
        end
      end
      stype: begin
        fmt   = fmt_s;
        imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      btype: begin
        fmt   = fmt_b;
        imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      utype_l, utype_u: begin
        fmt   = fmt_u;
        imm32 = {inst[31:12], 12'b0};
      end
      jtype: begin
        fmt   = fmt_j;
        imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      sys: begin
        if (funct3[2]) begin
          fmt   = fmt_zimm;
          imm32 = {27'b0, inst[19:15]};
        end
      end
      fence: ;
      default: illegal = 1'b1;
    endcase
  end

  // Zero-extended forms never set bit 31, so one sign extension serves all.
  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator with a 2-entry skid buffer on a
// valid/ready interface; in_ready and all out_* come straight from registers.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output fmt_e             out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  logic [XLEN-1:0]  ext_imm;
  fmt_e             ext_fmt;
  logic             ext_illegal;

  logic [XLEN-1:0]  skid_imm;
  fmt_e             skid_fmt;
  logic             skid_illegal;
  logic [TAG_W-1:0] skid_tag;

  state_e state_q, state_d;
  logic   accept;
  logic   load_out, load_skid, from_skid;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .inst    (in_inst),
    .imm     (ext_imm),
    .fmt     (ext_fmt),
    .illegal (ext_illegal)
  );

  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q != st_empty);

  always_comb begin
    state_d   = state_q;
    load_out  = 1'b0;
    load_skid = 1'b0;
    from_skid = 1'b0;
    case (state_q)
      st_empty: begin
        if (accept) begin
          load_out = 1'b1;
          state_d  = st_busy;
        end
      end
      st_busy: begin
        if (out_ready && accept) begin
          load_out = 1'b1;
        end else if (out_ready) begin
          state_d = st_empty;
        end else if (accept) begin
          load_skid = 1'b1;
          state_d   = st_full;
        end
      end
      st_full: begin
        if (out_ready) begin
          from_skid = 1'b1;
          state_d   = st_busy;
        end
      end
      default: state_d = st_empty;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= st_empty;
      in_ready <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_ready <= (state_d != st_full);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_imm     <= '0;
      out_fmt     <= fmt_none;
      out_illegal <= 1'b0;
      out_tag     <= '0;
    end else if (load_out) begin
      out_imm     <= ext_imm;
      out_fmt     <= ext_fmt;
      out_illegal <= ext_illegal;
      out_tag     <= in_tag;
    end else if (from_skid) begin
      out_imm     <= skid_imm;
      out_fmt     <= skid_fmt;
      out_illegal <= skid_illegal;
      out_tag     <= skid_tag;
    end
  end

  // NOTE: skid payload is deliberately not reset; it is only read when the
  // FSM says it is valid, so reset on the state alone is sufficient.
  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_imm     <= ext_imm;
      skid_fmt     <= ext_fmt;
      skid_illegal <= ext_illegal;
      skid_tag     <= in_tag;
    end
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Registered, parametrised RISC-V immediate generator for the decode stage, the successor to the combinational immediate generator. It extracts and sign- or zero-extends the immediate for every base-ISA format plus shift-amount and CSR-zimm forms. It reports the format and flags illegal opcodes. A valid/ready interface with a 2-entry skid buffer lets fetch/decode stall without combinational ready paths.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64.
- TAG_W, 8: width of the sideband tag (PC index, ROB id) carried alongside the instruction.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  instruction word present.
- in_ready  out  1  block can accept this cycle.
- in_inst  in  32  instruction word.
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts this cycle.
- out_imm  out  XLEN  extended immediate.
- out_fmt  out  3  immediate format code (package enum).
- out_illegal  out  1  opcode or shamt not legal for XLEN.
- out_tag  out  TAG_W  tag of the result.

## Operation
- Decode is on inst[6:0]:
  - I: LOAD 0000011, OP-IMM 0010011, JALR 1100111, OP-IMM-32 0011011 (XLEN=64 only). Result is sign-extended inst[31:20].
  - S: 0100011. Result is sign-extended {inst[31:25],inst[11:7]}.
  - B: 1100011. Result is sign-extended {inst[31],inst[7],inst[30:25],inst[11:8],0}.
  - U: LUI 0110111, AUIPC 0010111. Result is sign-extended {inst[31:12],12'b0}; upper 32 bits on RV64 are copies of inst[31].
  - J: 1101111. Result is sign-extended {inst[31],inst[19:12],inst[20],inst[30:21],0}.
  - SHAMT: OP-IMM, or OP-IMM-32, with funct3 001 or 101. Result is zero-extended shamt:
    - inst[24:20] when XLEN=32 or for OP-IMM-32;
    - inst[25:20] when XLEN=64.
    - XLEN=32 with inst[25]=1 sets illegal, with imm still equal to inst[24:20].
  - ZIMM: SYSTEM 1110011 with funct3[2]=1. Result is zero-extended inst[19:15].
  - SYSTEM with funct3[2]=0 is NONE, legal, imm 0.
  - FENCE 0001111 is NONE, legal, imm 0.
  - Any other opcode, including OP-IMM-32 when XLEN=32, is NONE, illegal=1, imm 0.
- Skid buffer FSM:
  - EMPTY: out_valid=0.
    - in_valid → load output register, go to BUSY.
  - BUSY: output register valid, skid empty.
    - out_ready & in_valid → reload output register, stay in BUSY.
    - out_ready & !in_valid → go to EMPTY.
    - !out_ready & in_valid → capture into skid, go to FULL.
  - FULL: both registers valid; in_ready=0.
    - out_ready → move skid into output register, go to BUSY.
- in_ready = !skid_valid; it is a pure register output. Inputs presented while in_ready=0 are ignored.
- Output fields are held stable while out_valid & !out_ready.
- Ordering is strictly FIFO, with no drops and no duplicates.

## Timing
- Latency is 1 cycle: a word accepted at edge N is visible at out_* after edge N when the output register was free.
- Throughput is 1 per cycle when out_ready stays high.
- While rst=1: in_ready=0, out_valid=0, out_imm=0, out_fmt=NONE, out_illegal=0, out_tag=0, FSM=EMPTY. in_ready=1 from the first cycle after rst drops.
- Reset mid-operation discards both held entries; nothing is replayed.
- Simultaneous accept and deliver in BUSY is a legal pass-through; the skid is untouched.
- There is no combinational path from out_ready to in_ready or from in_* to out_*.

## Structure
- Shared package imm_pkg holds:
  - the opcode constants (the existing ItypeL, ItypeA, ItypeJ, Stype, Btype, UtypeL, UtypeU and Jtype defines, plus OP-IMM-32, SYSTEM and FENCE);
  - the 3-bit fmt enum: NONE 0, I 1, S 2, B 3, U 4, J 5, SHAMT 6, ZIMM 7;
  - the FSM state encoding.
- Sub-module imm_extract: purely combinational (inst → imm, fmt, illegal), parametrised by XLEN, instantiated once ahead of the registers.
- The top holds the output register, the skid register and the FSM.

## Test plan
- XLEN=32, in_inst=0xFFF00093 (addi x1,x0,-1), out_ready=1 → next cycle: out_imm=0xFFFFFFFF, out_fmt=I, out_illegal=0, tag echoed.
- XLEN=32, in_inst=0xFE000EE3 (beq x0,x0,-4) → out_imm=0xFFFFFFFC, fmt=B. Then in_inst=0x12345037 (LUI) → out_imm=0x12345000, fmt=U.
- XLEN=32, in_inst=0x4030D093 (srai x1,x1,3) → imm=3, fmt=SHAMT. Then 0x300FD073 (csrrwi x0,mstatus,31) → imm=0x1F, fmt=ZIMM.
- XLEN=32:
  - in_inst=0x0000007F → imm 0, fmt NONE, illegal=1.
  - 0x0030809B (OP-IMM-32) → illegal=1.
  - 0x0200D093 (shamt bit 25 set) → illegal=1, imm 0.
  - XLEN=64: 0x0200D093 → imm=0x20, legal; 0xFFF00093 → 0xFFFF_FFFF_FFFF_FFFF.
- Backpressure: stream tags 1..6 with in_valid=1 while out_ready=0 for 3 cycles.
  - in_ready must fall after 2 accepts.
  - Release → tags 1..6 delivered in order, each exactly once; out_* stable while stalled.
- Assert rst for 1 cycle while in FULL → next cycle out_valid=0 and in_ready=1; a new word emerges with latency 1 and no stale entry appears.
